// File: rtl/wb_ddr_arbiter.sv
// Round-robin Wishbone arbiter sharing the ddr0 slave port among four masters; grant is held for a whole cyc.
// Optional slave-hang watchdog enabled by defining WB_DDR_ARBITER_WATCHDOG_EN.
//
// state | meaning
// IDLE  | no grant active, slave outputs quiet, picks next requester
// BUSY  | granted master drives the slave port until it drops cyc
// ABORT | watchdog fired; slave port quiet until granted master drops cyc
module wb_ddr_arbiter #(
    parameter int TIMEOUT  = 1024,
    parameter int TO_WIDTH = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   m_cyc_i,
    input  logic [3:0]   m_stb_i,
    input  logic [3:0]   m_we_i,
    input  logic [127:0] m_adr_i,
    input  logic [127:0] m_dat_i,
    input  logic [15:0]  m_sel_i,
    output logic [31:0]  m_dat_o,
    output logic [3:0]   m_ack_o,
    output logic [3:0]   m_err_o,
    output logic         s_cyc_o,
    output logic         s_stb_o,
    output logic         s_we_o,
    output logic [31:0]  s_adr_o,
    output logic [31:0]  s_dat_o,
    output logic [3:0]   s_sel_o,
    input  logic [31:0]  s_dat_i,
    input  logic         s_ack_i,
    input  logic         s_err_i,
    output logic [1:0]   grant_o,
    output logic         busy_o
);

    if ((1 << TO_WIDTH) < TIMEOUT) begin : g_bad_to_width
        $error("wb_ddr_arbiter: TO_WIDTH too narrow for TIMEOUT");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1
`ifdef WB_DDR_ARBITER_WATCHDOG_EN
        , ABORT = 2'd2
`endif
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] grant, grant_nxt;
    logic [1:0] last, last_nxt;
    logic [1:0] pick;

    // Scan from the farthest offset inward so the nearest requester after last wins.
    always_comb begin
        pick = last;
        for (int i = 4; i >= 1; i--) begin
            if (m_cyc_i[last + 2'(i)]) pick = last + 2'(i);
        end
    end

`ifdef WB_DDR_ARBITER_WATCHDOG_EN
    logic [TO_WIDTH-1:0] to_cnt;
    logic                no_resp;
    logic                to_hit;

    assign no_resp = (state == BUSY) && m_stb_i[grant] && !s_ack_i && !s_err_i;
    assign to_hit  = no_resp && (to_cnt == TO_WIDTH'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || state != BUSY || s_ack_i || s_err_i) to_cnt <= '0;
        else if (no_resp)                                  to_cnt <= to_cnt + TO_WIDTH'(1);
    end
`endif

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_dat_o   = s_dat_i;
        case (state)
            IDLE: begin
                if (|m_cyc_i) begin
                    grant_nxt = pick;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                s_cyc_o        = m_cyc_i[grant];
                s_stb_o        = m_stb_i[grant];
                s_we_o         = m_we_i[grant];
                s_adr_o        = m_adr_i[{grant, 5'b0} +: 32];
                s_dat_o        = m_dat_i[{grant, 5'b0} +: 32];
                s_sel_o        = m_sel_i[{grant, 2'b0} +: 4];
                m_ack_o[grant] = s_ack_i & m_stb_i[grant];
                m_err_o[grant] = s_err_i & m_stb_i[grant];
                if (!m_cyc_i[grant]) begin
                    state_nxt = IDLE;
                    last_nxt  = grant;
                end
`ifdef WB_DDR_ARBITER_WATCHDOG_EN
                else if (to_hit) begin
                    m_err_o[grant] = 1'b1;
                    state_nxt      = ABORT;
                end
`endif
            end
`ifdef WB_DDR_ARBITER_WATCHDOG_EN
            ABORT: begin
                if (!m_cyc_i[grant]) begin
                    state_nxt = IDLE;
                    last_nxt  = grant;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            grant <= 2'd0;
            last  <= 2'd3;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
        end
    end

    assign grant_o = grant;
    assign busy_o  = (state == BUSY);

endmodule

// File: tb/tb_wb_ddr_arbiter.sv
// Scoreboard bench for wb_ddr_arbiter: directed master cycles against a simple slave model.
module tb_wb_ddr_arbiter;

`ifdef WB_DDR_ARBITER_WATCHDOG_EN
    localparam int TO = 16;
    localparam int TW = 4;
`else
    localparam int TO = 1024;
    localparam int TW = 10;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
    logic [127:0] m_adr_i = '0, m_dat_i = '0;
    logic [15:0]  m_sel_i = '0;
    logic [31:0]  m_dat_o;
    logic [3:0]   m_ack_o, m_err_o;
    logic         s_cyc_o, s_stb_o, s_we_o;
    logic [31:0]  s_adr_o, s_dat_o;
    logic [3:0]   s_sel_o;
    logic [31:0]  s_dat_i = '0;
    logic         s_ack_i = 1'b0, s_err_i = 1'b0;
    logic [1:0]   grant_o;
    logic         busy_o;

    wb_ddr_arbiter #(.TIMEOUT(TO), .TO_WIDTH(TW)) dut (
        .clk(clk), .reset(reset),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0]  ack;
        logic [3:0]  err;
        logic [31:0] dat;
        bit          chk_dat;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_resp(input logic [3:0] ack, input logic [3:0] err,
                               input logic [31:0] dat, input bit chk_dat);
        exp_t e;
        e.ack = ack; e.err = err; e.dat = dat; e.chk_dat = chk_dat;
        exp_q.push_back(e);
    endtask

    // Slave model: responds after ack_delay wait cycles with data = slave_rdata ^ address.
    int          ack_delay = 1;
    bit          slave_hang = 1'b0;
    bit          slave_err = 1'b0;
    logic [31:0] slave_rdata = '0;
    int          wcnt = 0;

    always @(posedge clk) begin : slave
        logic        go;
        logic [31:0] a;
        go = s_cyc_o && s_stb_o && !s_ack_i && !s_err_i;
        a  = s_adr_o;
        #1;
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        if (go && !slave_hang) begin
            if (wcnt >= ack_delay) begin
                if (slave_err) s_err_i = 1'b1;
                else           s_ack_i = 1'b1;
                s_dat_i = slave_rdata ^ a;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (m_ack_o != 4'b0 || m_err_o != 4'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected ack=%b err=%b required=none", m_ack_o, m_err_o);
            end else begin
                e = exp_q.pop_front();
                check("sb_ack", 32'(m_ack_o), 32'(e.ack));
                check("sb_err", 32'(m_err_o), 32'(e.err));
                if (e.chk_dat) check("sb_dat", m_dat_o, e.dat);
            end
        end
    end

    int grant_log[$];
    int gap_log[$];
    bit busy_prev = 1'b0;
    int gap = 0;

    always @(negedge clk) begin
        if (busy_o) begin
            if (!busy_prev) begin
                grant_log.push_back(int'(grant_o));
                gap_log.push_back(gap);
            end
            gap = 0;
        end else begin
            gap++;
        end
        busy_prev = busy_o;
    end

    task automatic raise(input int m, input logic [31:0] adr, input logic we,
                         input logic [31:0] dat, input logic [3:0] sel);
        m_cyc_i[m] = 1'b1;
        m_stb_i[m] = 1'b1;
        m_we_i[m]  = we;
        m_adr_i[32*m +: 32] = adr;
        m_dat_i[32*m +: 32] = dat;
        m_sel_i[4*m +: 4]   = sel;
    endtask

    task automatic drop(input int m);
        m_cyc_i[m] = 1'b0;
        m_stb_i[m] = 1'b0;
        m_we_i[m]  = 1'b0;
    endtask

    task automatic wait_resp(input int m, input string name);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(m_ack_o[m] || m_err_o[m]) && t < 200);
        check(name, 32'(m_ack_o[m] | m_err_o[m]), 32'd1);
    endtask

    task automatic master_cycle(input int m, input logic [31:0] adr, input logic we,
                                input logic [31:0] dat, input logic [3:0] sel, input int beats);
        @(posedge clk); #1;
        raise(m, adr, we, dat, sel);
        for (int b = 0; b < beats; b++) begin
            wait_resp(m, "resp_timeout");
            if (b < beats - 1) begin
                @(posedge clk); #1 m_stb_i[m] = 1'b0;
                @(posedge clk); #1 m_stb_i[m] = 1'b1;
            end
        end
        @(posedge clk); #1;
        drop(m);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        m_cyc_i = '0;
        m_stb_i = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check_grants(input string tag, input int n, input int g[5]);
        check({tag, "_ngrants"}, grant_log.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < grant_log.size()) check($sformatf("%s_grant%0d", tag, i), grant_log[i], g[i]);
            if (i > 0 && i < gap_log.size()) check($sformatf("%s_gap%0d", tag, i), gap_log[i], 1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    int g_t2[5] = '{0, 1, 2, 3, 0};
    int g_t3[5] = '{1, 2, 0, 0, 0};
    int g_t4[5] = '{2, 0, 0, 0, 0};
    logic [31:0] rd = 32'h0F0F_1234;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_s_cyc", 32'(s_cyc_o), 0);
        check("rst_s_stb", 32'(s_stb_o), 0);
        check("rst_s_we",  32'(s_we_o), 0);
        check("rst_s_adr", s_adr_o, 0);
        check("rst_s_sel", 32'(s_sel_o), 0);
        check("rst_m_ack", 32'(m_ack_o), 0);
        check("rst_busy",  32'(busy_o), 0);
        check("rst_grant", 32'(grant_o), 0);

        // Single read from master 0 with latency check
        slave_rdata = 32'hCAFEBABE ^ 32'h4000_0010;
        expect_resp(4'b0001, 4'b0000, 32'hCAFEBABE, 1'b1);
        @(posedge clk); #1 raise(0, 32'h4000_0010, 1'b0, 32'h0, 4'hF);
        @(negedge clk);
        check("t1_cyc_pre", 32'(s_cyc_o), 0);
        @(negedge clk);
        check("t1_cyc", 32'(s_cyc_o), 1);
        check("t1_adr", s_adr_o, 32'h4000_0010);
        check("t1_grant", 32'(grant_o), 0);
        check("t1_busy", 32'(busy_o), 1);
        wait_resp(0, "t1_resp");
        @(posedge clk); #1 drop(0);
        @(negedge clk);
        check("t1_cyc_drop", 32'(s_cyc_o), 0);

        // All four request at once: rotate 0,1,2,3 then master 0 again
        do_reset();
        slave_rdata = rd;
        grant_log.delete(); gap_log.delete();
        expect_resp(4'b0001, 4'b0, rd ^ 32'h1000_0000, 1'b1);
        expect_resp(4'b0010, 4'b0, rd ^ 32'h1000_0100, 1'b1);
        expect_resp(4'b0100, 4'b0, rd ^ 32'h1000_0200, 1'b1);
        expect_resp(4'b1000, 4'b0, rd ^ 32'h1000_0300, 1'b1);
        expect_resp(4'b0001, 4'b0, rd ^ 32'h1000_0400, 1'b1);
        fork
            begin
                master_cycle(0, 32'h1000_0000, 1'b0, 32'h0, 4'hF, 1);
                master_cycle(0, 32'h1000_0400, 1'b0, 32'h0, 4'hF, 1);
            end
            master_cycle(1, 32'h1000_0100, 1'b0, 32'h0, 4'hF, 1);
            master_cycle(2, 32'h1000_0200, 1'b0, 32'h0, 4'hF, 1);
            master_cycle(3, 32'h1000_0300, 1'b0, 32'h0, 4'hF, 1);
        join
        repeat (3) @(negedge clk);
        check_grants("t2", 5, g_t2);

        // Master 1 holds cyc for 4 beats while master 2 waits
        grant_log.delete(); gap_log.delete();
        repeat (4) expect_resp(4'b0010, 4'b0, rd ^ 32'h2000_0100, 1'b1);
        expect_resp(4'b0100, 4'b0, rd ^ 32'h2000_0200, 1'b1);
        fork
            master_cycle(1, 32'h2000_0100, 1'b0, 32'h0, 4'hF, 4);
            master_cycle(2, 32'h2000_0200, 1'b0, 32'h0, 4'hF, 1);
        join
        repeat (3) @(negedge clk);
        check_grants("t3", 2, g_t3);

        // Master 2 write while master 0 also requests
        grant_log.delete(); gap_log.delete();
        expect_resp(4'b0100, 4'b0, rd ^ 32'h3000_0020, 1'b1);
        expect_resp(4'b0001, 4'b0, rd ^ 32'h3000_0000, 1'b1);
        fork
            master_cycle(2, 32'h3000_0020, 1'b1, 32'hDEAD_BEEF, 4'b0011, 1);
            begin
                @(posedge clk);
                master_cycle(0, 32'h3000_0000, 1'b0, 32'h0, 4'hF, 1);
            end
            begin
                @(posedge clk);
                @(negedge clk);
                @(negedge clk);
                check("t4_grant", 32'(grant_o), 2);
                check("t4_we", 32'(s_we_o), 1);
                check("t4_sel", 32'(s_sel_o), 32'h3);
                check("t4_dat", s_dat_o, 32'hDEAD_BEEF);
                check("t4_adr", s_adr_o, 32'h3000_0020);
                check("t4_m0_req", 32'(m_cyc_i[0]), 1);
                check("t4_m0_quiet", 32'({m_ack_o[0], m_err_o[0]}), 0);
            end
        join
        repeat (3) @(negedge clk);
        check_grants("t4", 2, g_t4);

        // Slave error routed to master 3 only
        slave_err = 1'b1;
        expect_resp(4'b0000, 4'b1000, rd ^ 32'h4000_0000, 1'b1);
        master_cycle(3, 32'h4000_0000, 1'b0, 32'h0, 4'hF, 1);
        slave_err = 1'b0;

        // Reset mid-cycle, master 0 wins afterwards
        slave_hang = 1'b1;
        @(posedge clk); #1 raise(1, 32'h5000_0000, 1'b0, 32'h0, 4'hF);
        repeat (3) @(negedge clk);
        check("t6_busy", 32'(busy_o), 1);
        check("t6_grant", 32'(grant_o), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        raise(0, 32'h5000_0040, 1'b0, 32'h0, 4'hF);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("t6_rst_cyc", 32'(s_cyc_o), 0);
        check("t6_rst_busy", 32'(busy_o), 0);
        check("t6_rst_grant", 32'(grant_o), 0);
        @(negedge clk);
        check("t6_first_grant", 32'(grant_o), 0);
        check("t6_first_busy", 32'(busy_o), 1);
        expect_resp(4'b0001, 4'b0, rd ^ 32'h5000_0040, 1'b1);
        expect_resp(4'b0010, 4'b0, rd ^ 32'h5000_0000, 1'b1);
        slave_hang = 1'b0;
        wait_resp(0, "t6_m0_resp");
        @(posedge clk); #1 drop(0);
        wait_resp(1, "t6_m1_resp");
        @(posedge clk); #1 drop(1);

`ifdef WB_DDR_ARBITER_WATCHDOG_EN
        begin
            int k = 0;
            int t = 0;
            do_reset();
            slave_hang = 1'b1;
            expect_resp(4'b0000, 4'b0001, 32'h0, 1'b0);
            @(posedge clk); #1 raise(0, 32'h6000_0000, 1'b0, 32'h0, 4'hF);
            do begin
                @(negedge clk);
                t++;
                if (busy_o) k++;
            end while (!m_err_o[0] && t < 100);
            check("wd_err_cycle", k, 16);
            @(negedge clk);
            check("wd_abort_cyc", 32'(s_cyc_o), 0);
            check("wd_abort_busy", 32'(busy_o), 0);
            check("wd_err_once", 32'(m_err_o), 0);
            @(posedge clk); #1 raise(1, 32'h6000_0100, 1'b0, 32'h0, 4'hF);
            repeat (2) @(negedge clk);
            check("wd_abort_hold", 32'(s_cyc_o), 0);
            @(posedge clk); #1 drop(0);
            slave_hang = 1'b0;
            expect_resp(4'b0010, 4'b0, rd ^ 32'h6000_0100, 1'b1);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!busy_o && t < 20);
            check("wd_next_busy", 32'(busy_o), 1);
            check("wd_next_grant", 32'(grant_o), 1);
            wait_resp(1, "wd_m1_resp");
            @(posedge clk); #1 drop(1);
        end
`endif

        repeat (3) @(negedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_ddr_arbiter.md
Name: wb_ddr_arbiter

Overview:
Round-robin Wishbone arbiter that shares the single ddr0 slave port among four bus masters: lm32 data, lm32 instruction, and two future DMA/video masters.
- Sits between the masters and the DDR controller's Wishbone port, ahead of the address decode to ddr0.
- Holds a grant for a whole Wishbone cycle (cyc high) and never preempts mid-cycle.
- Exposes the grant state for debug/probe muxing.

Parameters:
TIMEOUT, 1024, slave-no-ack cycles before watchdog abort (used only with the optional feature).
TO_WIDTH, 10, watchdog counter width; must satisfy 2^TO_WIDTH >= TIMEOUT.

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
m_cyc_i  input  4  per-master cyc, bit n = master n
m_stb_i  input  4  per-master stb
m_we_i  input  4  per-master we
m_adr_i  input  128  per-master address, master n at [32n+31:32n]
m_dat_i  input  128  per-master write data, same packing
m_sel_i  input  16  per-master byte select, master n at [4n+3:4n]
m_dat_o  output  32  read data, broadcast to all masters
m_ack_o  output  4  per-master ack
m_err_o  output  4  per-master err
s_cyc_o  output  1  slave cyc
s_stb_o  output  1  slave stb
s_we_o  output  1  slave we
s_adr_o  output  32  slave address
s_dat_o  output  32  slave write data
s_sel_o  output  4  slave byte select
s_dat_i  input  32  slave read data
s_ack_i  input  1  slave ack
s_err_i  input  1  slave err
grant_o  output  2  index of the current/last granted master
busy_o  output  1  high while in BUSY

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset values: state=IDLE, grant=0, last=3 (master 0 wins first), s_cyc_o=s_stb_o=s_we_o=0, s_adr_o/s_dat_o/s_sel_o=0, m_ack_o=m_err_o=0, busy_o=0, grant_o=0.
- States are IDLE, BUSY and ABORT; ABORT exists only with the optional feature.
- IDLE:
  - All s_* outputs are 0.
  - If any m_cyc_i bit is set, register grant = first requester scanning last+1, last+2, last+3, last (mod 4), then go to BUSY.
  - Stay in IDLE if no bit is set.
- BUSY:
  - s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o/s_sel_o mirror the granted master's inputs combinationally.
  - m_ack_o[grant] = s_ack_i & m_stb_i[grant]; m_err_o[grant] = s_err_i & m_stb_i[grant]; all other ack/err bits are 0.
  - m_dat_o = s_dat_i at all times.
- Leaving BUSY: when m_cyc_i[grant]=0 in BUSY, next state is IDLE and last=grant.
  - Result: at least one dead cycle between different masters' cycles.
  - The same master re-requesting loses to any other pending requester.
- Latency: with all masters idle, a request first sampled at edge N gives s_cyc_o=1 from cycle N+1. Back-to-back cycles from one master cost one IDLE cycle.
- Simultaneous requests resolve strictly by rotating priority; no starvation.
  - Worst-case wait = 3 foreign cycles + 3 IDLE cycles.
- Multi-beat (stb toggling within cyc) and lock-by-cyc are honoured because the grant is tied to cyc only.
- Reset mid-cycle: next edge forces IDLE and drops s_cyc_o; the aborted master receives no ack.
- grant_o = registered grant; busy_o = (state==BUSY).

Optional Feature:
Macro WB_DDR_ARBITER_WATCHDOG_EN.
- Defined:
  - TO_WIDTH-bit counter cleared in IDLE and on every s_ack_i/s_err_i; increments each BUSY cycle with s_stb_o=1 and no ack/err.
  - When the counter reaches TIMEOUT-1 and a further no-ack cycle occurs: pulse m_err_o[grant] for exactly one cycle, then go to ABORT.
  - ABORT: s_cyc_o=s_stb_o=0 and all acks masked; stay until m_cyc_i[grant]=0, then IDLE with last=grant.
- Not defined: no counter, no ABORT state; a hung slave stalls the bus indefinitely; err comes only from s_err_i.

Test Plan:
- Reset, then m_cyc_i=4'b0001 with read at 0x40000010, slave acks 2 cycles later with 0xCAFEBABE → s_cyc_o rises 1 cycle after request, s_adr_o=0x40000010, m_ack_o=4'b0001 for one cycle, m_dat_o=0xCAFEBABE.
- m_cyc_i=4'b1111 held; each master drops cyc one cycle after its ack → grant_o sequence 0,1,2,3,0 with exactly one IDLE cycle between grants.
- Master 1 holds cyc for 4 stb/ack beats while master 2 requests → no switch until master 1 drops cyc; master 2 granted after one IDLE cycle; all 4 acks seen only on m_ack_o[1].
- Master 2 write with we=1, sel=4'b0011 while master 0 also requests → non-granted master sees m_ack_o/m_err_o=0; s_we_o/s_sel_o reflect master 2 only.
- Reset asserted in BUSY mid-cycle → next cycle s_cyc_o=0, busy_o=0, grant_o=0; the next request from master 0 is granted first.
- With WB_DDR_ARBITER_WATCHDOG_EN and TIMEOUT=16, slave never acks → m_err_o[grant] pulses once after 16 stb cycles, s_cyc_o=0 until master drops cyc, then the next master is granted.
